// File: rtl/tick_step_pkg.sv
// Shared types and constants for the tick/step clock-enable controller.
package tick_step_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam int DB_CNT_W = 20;

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: the output follows the already-synchronized input only
// after it has held the same level for DEBOUNCE_CYCLES consecutive clocks.
module btn_debounce
   import tick_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
)
(
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam logic [DB_CNT_W-1:0] LP_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [DB_CNT_W-1:0] r_cnt;
   logic                r_prev;
   logic                r_level;

   // Any edge on the input restarts the stability window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_prev  <= 1'b0;
         r_level <= 1'b0;
      end else begin
         r_prev <= raw;
         if (raw != r_prev) begin
            r_cnt <= '0;
         end else if (r_cnt != LP_LAST) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_level <= r_prev;
         end
      end
   end

   assign level = r_level;

endmodule

// File: rtl/tick_step_ctrl.sv
// Run/single-step controller: turns slow divider ticks into one-cycle clock
// enables for the processor datapath, gated by run switch, step button and halt.
module tick_step_ctrl
   import tick_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic             halt,
   output logic             step_en,
   output logic [CNT_W-1:0] tick_count,
   output logic [1:0]       state_o
);

   logic r_tick_s1, r_tick_s2, r_tick_s3;
   logic r_run_s1, r_run_s2;
   logic r_btn_s1, r_btn_s2;
   logic r_valid1, r_valid2, r_armed;
   logic r_tick_rise;
   logic r_btn_db_d, r_step_req, r_step_en;
   logic [CNT_W-1:0] r_count;
   state_t r_state, w_next;
   logic w_issue, w_btn_db;

   // Synchronizers plus edge detect; a tick only counts once the synced input
   // has been seen low, so a tick_in already high at reset release is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tick_s1   <= 1'b0;
         r_tick_s2   <= 1'b0;
         r_tick_s3   <= 1'b0;
         r_run_s1    <= 1'b0;
         r_run_s2    <= 1'b0;
         r_btn_s1    <= 1'b0;
         r_btn_s2    <= 1'b0;
         r_valid1    <= 1'b0;
         r_valid2    <= 1'b0;
         r_armed     <= 1'b0;
         r_tick_rise <= 1'b0;
      end else begin
         r_tick_s1   <= tick_in;
         r_tick_s2   <= r_tick_s1;
         r_tick_s3   <= r_tick_s2;
         r_run_s1    <= run_sw;
         r_run_s2    <= r_run_s1;
         r_btn_s1    <= step_btn;
         r_btn_s2    <= r_btn_s1;
         r_valid1    <= 1'b1;
         r_valid2    <= r_valid1;
         if (r_valid2 && !r_tick_s2) begin
            r_armed <= 1'b1;
         end
         r_tick_rise <= r_armed & r_tick_s2 & ~r_tick_s3;
      end
   end

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (r_btn_s2),
      .level(w_btn_db)
   );

   always_comb begin
      w_next  = r_state;
      w_issue = 1'b0;
      case (r_state)
         IDLE: begin
            if (halt) w_next = HALTED;
            else if (r_run_s2) w_next = RUN;
            else if (r_step_req) w_next = STEP;
         end
         RUN: begin
            if (halt) w_next = HALTED;
            else if (!r_run_s2) w_next = IDLE;
            else w_issue = r_tick_rise;
         end
         STEP: begin
            if (halt) begin
               w_next = HALTED;
            end else if (r_tick_rise) begin
               w_issue = 1'b1;
               w_next  = IDLE;
            end
         end
         HALTED: begin
            if (!halt && !r_run_s2) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Step requests are dropped in RUN/HALTED so a press made there never
   // turns into a stale step afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_btn_db_d <= 1'b0;
         r_step_req <= 1'b0;
         r_step_en  <= 1'b0;
         r_count    <= '0;
      end else begin
         r_state    <= w_next;
         r_btn_db_d <= w_btn_db;
         r_step_en  <= w_issue;
         if (r_state == RUN || r_state == HALTED ||
             (r_state == IDLE && w_next == STEP)) begin
            r_step_req <= 1'b0;
         end else if (w_btn_db && !r_btn_db_d) begin
            r_step_req <= 1'b1;
         end
         if (w_issue) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign step_en    = r_step_en;
   assign tick_count = r_count;
   assign state_o    = r_state;

endmodule

// File: tb/tb_tick_step_ctrl.sv
// Directed bench for tick_step_ctrl with a short debounce window and a
// 20-clock tick period; vector table plus hand-written corner sequences.
module tb_tick_step_ctrl;

   logic       clk;
   logic       rst;
   logic       tick_in;
   logic       run_sw;
   logic       step_btn;
   logic       halt;
   logic       step_en;
   logic [7:0] tick_count;
   logic [1:0] state_o;

   int testsRun;
   int testsFailed;
   int expCount;

   typedef struct {
      logic run;
      logic hlt;
      int   nTicks;
      int   expState;
      int   expPulses;
   } vec_t;

   vec_t vecs[6];

   tick_step_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick_in   (tick_in),
      .run_sw    (run_sw),
      .step_btn  (step_btn),
      .halt      (halt),
      .step_en   (step_en),
      .tick_count(tick_count),
      .state_o   (state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      testsRun++;
      if (act != exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One full tick period; counts step_en pulses and back-to-back highs.
   task automatic driveTick(output int pulses, output int doubles);
      logic prev;
      pulses  = 0;
      doubles = 0;
      prev    = 1'b0;
      tick_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (step_en) begin
            pulses++;
            if (prev) doubles++;
         end
         prev = step_en;
         if (i == 9) tick_in = 1'b0;
      end
   endtask

   task automatic doReset(input string name);
      rst = 1'b0;
      cycles(3);
      checkOutput({name, " step_en"}, int'(step_en), 0);
      checkOutput({name, " state"}, int'(state_o), 0);
      checkOutput({name, " count"}, int'(tick_count), 0);
      rst = 1'b1;
      expCount = 0;
      cycles(3);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      int p, d, totP, totD;
      totP = 0;
      totD = 0;
      run_sw = v.run;
      halt   = v.hlt;
      cycles(6);
      for (int t = 0; t < v.nTicks; t++) begin
         driveTick(p, d);
         totP += p;
         totD += d;
      end
      expCount = (expCount + v.expPulses) % 256;
      checkOutput($sformatf("vec%0d state", idx), int'(state_o), v.expState);
      checkOutput($sformatf("vec%0d pulses", idx), totP, v.expPulses);
      checkOutput($sformatf("vec%0d doubles", idx), totD, 0);
      checkOutput($sformatf("vec%0d count", idx), int'(tick_count), expCount);
   endtask

   initial begin
      int p, d, totP, seen;
      testsRun    = 0;
      testsFailed = 0;
      expCount    = 0;
      rst      = 1'b0;
      tick_in  = 1'b0;
      run_sw   = 1'b0;
      step_btn = 1'b0;
      halt     = 1'b0;

      vecs[0] = '{1'b1, 1'b0, 5, 1, 5};
      vecs[1] = '{1'b1, 1'b1, 3, 3, 0};
      vecs[2] = '{1'b1, 1'b0, 2, 3, 0};
      vecs[3] = '{1'b0, 1'b0, 2, 0, 0};
      vecs[4] = '{1'b1, 1'b0, 3, 1, 3};
      vecs[5] = '{1'b0, 1'b0, 2, 0, 0};

      cycles(2);
      doReset("reset0");

      // Bouncing press, then a clean 6-cycle hold: exactly one step.
      step_btn = 1'b1; cycles(1);
      step_btn = 1'b0; cycles(1);
      step_btn = 1'b1; cycles(6);
      step_btn = 1'b0;
      cycles(15);
      checkOutput("btn state STEP", int'(state_o), 2);
      driveTick(p, d);
      checkOutput("btn step pulses", p, 1);
      checkOutput("btn back IDLE", int'(state_o), 0);
      checkOutput("btn count", int'(tick_count), 1);
      driveTick(p, d);
      checkOutput("btn no extra", p, 0);

      doReset("reset1");
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

      // Latency: enable appears after the 4th edge following the tick rise.
      run_sw = 1'b1;
      cycles(6);
      tick_in = 1'b1;
      cycles(3);
      checkOutput("latency edge3", int'(step_en), 0);
      cycles(1);
      checkOutput("latency edge4", int'(step_en), 1);
      cycles(1);
      checkOutput("latency single", int'(step_en), 0);
      expCount = (expCount + 1) % 256;
      cycles(6);
      tick_in = 1'b0;
      cycles(10);
      checkOutput("latency count", int'(tick_count), expCount);

      // Halt arriving in the same cycle as the registered tick rise.
      tick_in = 1'b1;
      cycles(3);
      halt = 1'b1;
      totP = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (step_en) totP++;
         if (i == 6) tick_in = 1'b0;
      end
      checkOutput("halt coincident pulses", totP, 0);
      checkOutput("halt state", int'(state_o), 3);
      halt = 1'b0;
      cycles(6);
      checkOutput("halt run held", int'(state_o), 3);
      run_sw = 1'b0;
      cycles(6);
      checkOutput("halt release", int'(state_o), 0);
      checkOutput("halt count", int'(tick_count), expCount);

      // Press made during RUN must not survive into IDLE.
      run_sw = 1'b1;
      cycles(6);
      step_btn = 1'b1;
      cycles(15);
      checkOutput("stale in RUN", int'(state_o), 1);
      run_sw = 1'b0;
      cycles(6);
      checkOutput("stale to IDLE", int'(state_o), 0);
      driveTick(p, d);
      checkOutput("stale pulses", p, 0);
      checkOutput("stale stays IDLE", int'(state_o), 0);
      step_btn = 1'b0;
      cycles(15);
      checkOutput("stale after release", int'(state_o), 0);

      // Counter wrap over 257 ticks.
      doReset("reset2");
      run_sw = 1'b1;
      cycles(6);
      totP = 0;
      for (int t = 0; t < 257; t++) begin
         driveTick(p, d);
         totP += p;
      end
      checkOutput("wrap pulses", totP, 257);
      checkOutput("wrap count", int'(tick_count), 1);

      // Reset while step_en is high, released with tick_in still high.
      tick_in = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         @(negedge clk);
         if (step_en) seen = 1;
      end
      checkOutput("rst saw step_en", seen, 1);
      rst = 1'b0;
      #1;
      checkOutput("rst drops step_en", int'(step_en), 0);
      checkOutput("rst state", int'(state_o), 0);
      checkOutput("rst count", int'(tick_count), 0);
      cycles(3);
      rst = 1'b1;
      totP = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (step_en) totP++;
      end
      checkOutput("rst no stale tick", totP, 0);
      checkOutput("rst back in RUN", int'(state_o), 1);
      tick_in = 1'b0;
      cycles(10);
      driveTick(p, d);
      checkOutput("rst fresh tick", p, 1);
      checkOutput("rst fresh count", int'(tick_count), 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/tick_step_ctrl.md
TICK_STEP_CTRL -- requirements
Module: tick_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable clk cycles required to accept a new step_btn level.
REQ-002 Parameter CNT_W, default 8, width of tick_count.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 tick_in  input  1  divided slow clock from the clock divider, asynchronous to this block's sampling; a rising edge means one tick.
REQ-006 run_sw  input  1  raw switch level, 1 = continuous run, 0 = stop.
REQ-007 step_btn  input  1  raw push button, 1 = pressed, bouncing.
REQ-008 halt  input  1  processor halted flag, level.
REQ-009 step_en  output  1  one-cycle clock-enable to the processor datapath.
REQ-010 tick_count  output  CNT_W  number of step_en pulses issued, modulo 2^CNT_W.
REQ-011 state_o  output  2  current FSM state encoding.

Function
REQ-012 tick_in, run_sw and step_btn SHALL each pass through a 2-flop synchronizer (s1, s2).
REQ-013 tick_rise SHALL equal s2 & ~s3, where s3 is one further register on synced tick_in; high for exactly one cycle per tick_in rising edge.
REQ-014 Debounce: a 20-bit counter SHALL restart on every change of synced step_btn; btn_db SHALL take the synced level when the counter reaches DEBOUNCE_CYCLES-1.
REQ-015 A 0->1 transition of btn_db SHALL set step_req; step_req SHALL clear when consumed (IDLE->STEP) or when the FSM is in RUN or HALTED.
REQ-016 FSM states: IDLE=0, RUN=1, STEP=2, HALTED=3; priority halt > run_sw > step_req.
REQ-017 IDLE: halt -> HALTED; else run_sw=1 -> RUN; else step_req -> STEP; else stay.
REQ-018 RUN: halt -> HALTED; else run_sw=0 -> IDLE; else stay and issue step_en on every tick_rise.
REQ-019 STEP: halt -> HALTED; else on tick_rise issue one step_en and go to IDLE; run_sw changes are ignored while in STEP.
REQ-020 HALTED: no step_en; -> IDLE only when halt=0 and synced run_sw=0.
REQ-021 step_en SHALL be registered: high in the cycle after tick_rise in RUN/STEP, never high two consecutive cycles, never high in IDLE/HALTED.
REQ-022 Latency: tick_in rising (meeting setup) -> step_en high after the 4th posedge clk.
REQ-023 halt and tick_rise in the same cycle SHALL suppress that step_en.
REQ-024 tick_count SHALL increment on each step_en and wrap from 2^CNT_W-1 to 0.

Reset
REQ-025 rst=0 SHALL asynchronously clear all synchronizers, debounce counter, btn_db, step_req, tick_count and step_en to 0, and force state IDLE.
REQ-026 Reset mid-operation SHALL drop step_en immediately; after release the first step_en requires a fresh tick_in rising edge.

Structure
REQ-027 State enum (2-bit) and DEBOUNCE counter width constant SHALL live in a shared package, tick_step_pkg.
REQ-028 Debounce logic SHALL be one sub-module, btn_debounce (clk, rst, raw, level); synchronizers and FSM stay in tick_step_ctrl.

Verification (DEBOUNCE_CYCLES=4, tick_in period 20 clk)
REQ-029 run_sw=1, 5 tick_in rises -> 5 single-cycle step_en pulses, each 4 edges after its tick rise, tick_count=5.
REQ-030 run_sw=0, step_btn bounces 1/0/1 then held 1 for 6 cycles -> exactly one STEP entry, one step_en on next tick, state back to IDLE, tick_count=1.
REQ-031 RUN, halt=1 coincident with tick_rise -> no step_en, state=3; halt=0 with run_sw=1 -> stays HALTED; run_sw=0 -> IDLE.
REQ-032 CNT_W=8, 257 ticks in RUN -> tick_count=1.
REQ-033 rst=0 asserted while step_en high -> step_en 0 same cycle, state_o=0, tick_count=0.
REQ-034 step_btn press held during RUN, then run_sw=0 -> IDLE with no stale STEP and no extra step_en.
